// File: rtl/tri_inside_test_if.sv
// Handshake bundle for the inside-triangle stage: show-ahead input FIFO side
// plus the single-entry output slot.
interface tri_inside_test_if;
    logic signed [31:0] p          [3];
    logic signed [31:0] v0         [3];
    logic signed [31:0] v1         [3];
    logic signed [31:0] v2         [3];
    logic signed [31:0] tri_normal [3];
    logic               in_empty;
    logic               in_rd_en;
    logic               out_hit;
    logic signed [31:0] out_p      [3];
    logic               out_empty;
    logic               out_rd_en;

    modport master (
        output p, v0, v1, v2, tri_normal, in_empty, out_rd_en,
        input  in_rd_en, out_hit, out_p, out_empty
    );

    modport slave (
        input  p, v0, v1, v2, tri_normal, in_empty, out_rd_en,
        output in_rd_en, out_hit, out_p, out_empty
    );
endinterface

// File: rtl/tri_inside_test.sv
// Inside-triangle test: three edge cross/dot sign checks sharing one datapath,
// with early exit on the first failing edge and a one-entry output slot.
module tri_inside_test #(
    parameter int unsigned Q_BITS = 16
) (
    input logic               clk,
    input logic               rst_n,
    tri_inside_test_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StCross, StDot} state_e;

    state_e             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic signed [31:0] p_q     [3];
    logic signed [31:0] p_d     [3];
    logic signed [31:0] vtx_q   [3][3];
    logic signed [31:0] vtx_d   [3][3];
    logic signed [31:0] n_q     [3];
    logic signed [31:0] n_d     [3];
    logic signed [31:0] cross_q [3];
    logic signed [31:0] cross_d [3];
    logic               out_hit_q, out_hit_d;
    logic signed [31:0] out_p_q [3];
    logic signed [31:0] out_p_d [3];
    logic               out_empty_q, out_empty_d;

    logic signed [31:0] va [3];
    logic signed [31:0] vb [3];
    logic signed [31:0] e  [3];
    logic signed [31:0] c  [3];
    logic signed [63:0] cross_full [3];
    logic signed [65:0] dot;
    logic               dot_pass;
    logic               in_rd_en;

    // Shared edge datapath: select the edge endpoints for the current k.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        unique case (k_q)
            2'd0: for (int i = 0; i < 3; i++) begin
                va[i] = vtx_q[0][i];
                vb[i] = vtx_q[1][i];
            end
            2'd1: for (int i = 0; i < 3; i++) begin
                va[i] = vtx_q[1][i];
                vb[i] = vtx_q[2][i];
            end
            default: for (int i = 0; i < 3; i++) begin
                va[i] = vtx_q[2][i];
                vb[i] = vtx_q[0][i];
            end
        endcase
        for (int i = 0; i < 3; i++) begin
            e[i] = vb[i] - va[i];
            c[i] = p_q[i] - va[i];
        end
        cross_full[0] = 64'(e[1]) * 64'(c[2]) - 64'(e[2]) * 64'(c[1]);
        cross_full[1] = 64'(e[2]) * 64'(c[0]) - 64'(e[0]) * 64'(c[2]);
        cross_full[2] = 64'(e[0]) * 64'(c[1]) - 64'(e[1]) * 64'(c[0]);
        dot = 66'(64'(n_q[0]) * 64'(cross_q[0]))
            + 66'(64'(n_q[1]) * 64'(cross_q[1]))
            + 66'(64'(n_q[2]) * 64'(cross_q[2]));
        dot_pass = (dot >= 66'sd0);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        p_d         = p_q;
        vtx_d       = vtx_q;
        n_d         = n_q;
        cross_d     = cross_q;
        out_hit_d   = out_hit_q;
        out_p_d     = out_p_q;
        out_empty_d = out_empty_q;

        // Accept only when the slot is free now or is being popped this cycle.
        in_rd_en = rst_n && (state_q == StIdle) && !bus.in_empty
                   && (out_empty_q || bus.out_rd_en);

        if (bus.out_rd_en && !out_empty_q) begin
            out_empty_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (in_rd_en) begin
                    for (int i = 0; i < 3; i++) begin
                        p_d[i]      = bus.p[i];
                        vtx_d[0][i] = bus.v0[i];
                        vtx_d[1][i] = bus.v1[i];
                        vtx_d[2][i] = bus.v2[i];
                        n_d[i]      = bus.tri_normal[i];
                    end
                    k_d     = 2'd0;
                    state_d = StCross;
                end
            end
            StCross: begin
                for (int i = 0; i < 3; i++) begin
                    cross_d[i] = 32'(cross_full[i] >>> Q_BITS);
                end
                state_d = StDot;
            end
            StDot: begin
                if (!dot_pass || k_q == 2'd2) begin
                    out_hit_d   = dot_pass;
                    out_p_d     = p_q;
                    out_empty_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    k_d     = k_q + 2'd1;
                    state_d = StCross;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= 2'd0;
            p_q         <= '{default: '0};
            vtx_q       <= '{default: '0};
            n_q         <= '{default: '0};
            cross_q     <= '{default: '0};
            out_hit_q   <= 1'b0;
            out_p_q     <= '{default: '0};
            out_empty_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            p_q         <= p_d;
            vtx_q       <= vtx_d;
            n_q         <= n_d;
            cross_q     <= cross_d;
            out_hit_q   <= out_hit_d;
            out_p_q     <= out_p_d;
            out_empty_q <= out_empty_d;
        end
    end

    assign bus.in_rd_en  = in_rd_en;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_empty = out_empty_q;
endmodule
